// File: rtl/store_checker_pkg.sv
// rtl/store_checker_pkg.sv - shared state and fail-code types for the store checker
package store_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISMATCH = 2'b01,
        FC_TIMEOUT  = 2'b10,
        FC_EMPTY    = 2'b11
    } fail_code_t;

    // Counter width that stays legal for a count limit of 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/store_checker_exp_fifo.sv
// rtl/store_checker_exp_fifo.sv - expected-store table, circular FIFO with occupancy count
module exp_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic         full,
    output logic         empty,
    output logic         one_left,
    output logic [W-1:0] head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign one_left = (count_q == CW'(1));
    assign do_push  = push && !full && !clr;
    assign do_pop   = pop && !empty && !clr;
    assign head     = mem[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/store_checker.sv
// rtl/store_checker.sv - checks processor stores against a table of expected stores
// Optional STORE_CHECKER_CAPTURE_EN latches the address/data of the mismatching store.
module store_checker
    import store_checker_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADR_W   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mem_write,
    input  logic [ADR_W-1:0]             data_adr,
    input  logic [DATA_W-1:0]            write_data,
    input  logic                         exp_we,
    input  logic [ADR_W-1:0]             exp_adr,
    input  logic [DATA_W-1:0]            exp_data,
    input  logic                         ign_en,
    input  logic [ADR_W-1:0]             ign_adr,
    input  logic                         start,
    input  logic                         clear,
    output logic                         busy,
    output logic                         pass,
    output logic                         fail,
    output logic [1:0]                   fail_code,
    output logic [$clog2(DEPTH+1)-1:0]   match_cnt,
    output logic                         ovf,
    output logic [ADR_W-1:0]             fail_adr,
    output logic [DATA_W-1:0]            fail_data
);

    localparam int EW    = ADR_W + DATA_W;
    localparam int MC_W  = $clog2(DEPTH + 1);
    localparam int CNT_W = cnt_width(TIMEOUT);

    state_t            state_q, state_d;
    fail_code_t        code_q, code_d;
    logic [MC_W-1:0]   mc_q, mc_d;
    logic [CNT_W-1:0]  tmr_q, tmr_d;
    logic              ovf_q, ovf_d;

    logic              fifo_push, fifo_pop;
    logic              fifo_full, fifo_empty, fifo_one_left;
    logic [EW-1:0]     head;
    logic              head_match, ign_hit;

    exp_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_exp_fifo (
        .clk       (clk),
        .reset     (reset),
        .clr       (clear),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .push_data ({exp_adr, exp_data}),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .one_left  (fifo_one_left),
        .head      (head)
    );

    assign head_match = mem_write && (head == {data_adr, write_data});
    assign ign_hit    = mem_write && ign_en && (data_adr == ign_adr);

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        mc_d      = mc_q;
        tmr_d     = tmr_q;
        ovf_d     = ovf_q;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (clear) begin
            state_d = IDLE;
            code_d  = FC_NONE;
            mc_d    = '0;
            tmr_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (exp_we) begin
                        if (fifo_full) ovf_d     = 1'b1;
                        else           fifo_push = 1'b1;
                    end
                    if (start) begin
                        if (fifo_empty) begin
                            state_d = FAIL;
                            code_d  = FC_EMPTY;
                        end else begin
                            state_d = RUN;
                            tmr_d   = '0;
                            mc_d    = '0;
                        end
                    end
                end
                RUN: begin
                    tmr_d = tmr_q + CNT_W'(1);
                    // Head match outranks the scratch-address ignore rule.
                    if (head_match) begin
                        fifo_pop = 1'b1;
                        mc_d     = mc_q + MC_W'(1);
                        if (fifo_one_left) state_d = PASS;
                    end else if (mem_write && !ign_hit) begin
                        state_d = FAIL;
                        code_d  = FC_MISMATCH;
                    end
                    if (state_d == RUN && tmr_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d = FAIL;
                        code_d  = FC_TIMEOUT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            code_q  <= FC_NONE;
            mc_q    <= '0;
            tmr_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            mc_q    <= mc_d;
            tmr_q   <= tmr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign pass      = (state_q == PASS);
    assign fail      = (state_q == FAIL);
    assign fail_code = code_q;
    assign match_cnt = mc_q;
    assign ovf       = ovf_q;

`ifdef STORE_CHECKER_CAPTURE_EN
    logic [ADR_W-1:0]  fa_q, fa_d;
    logic [DATA_W-1:0] fd_q, fd_d;
    logic              capture;

    assign capture = !clear && (state_q == RUN) && mem_write && !head_match && !ign_hit;

    always_comb begin
        fa_d = fa_q;
        fd_d = fd_q;
        if (clear) begin
            fa_d = '0;
            fd_d = '0;
        end else if (capture) begin
            fa_d = data_adr;
            fd_d = write_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fa_q <= '0;
            fd_q <= '0;
        end else begin
            fa_q <= fa_d;
            fd_q <= fd_d;
        end
    end

    assign fail_adr  = fa_q;
    assign fail_data = fd_q;
`else
    assign fail_adr  = '0;
    assign fail_data = '0;
`endif

endmodule

// File: tb/tb_store_checker.sv
// tb/tb_store_checker.sv - scoreboard bench for store_checker with a transaction-level reference model
module tb_store_checker;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 20;
    localparam int NSTEP   = TIMEOUT + 2;
`ifdef STORE_CHECKER_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] data_adr = '0, write_data = '0;
    logic        exp_we = 1'b0;
    logic [31:0] exp_adr = '0, exp_data = '0;
    logic        ign_en = 1'b0;
    logic [31:0] ign_adr = '0;
    logic        start = 1'b0, clear = 1'b0;
    logic        busy, pass, fail, ovf;
    logic [1:0]  fail_code;
    logic [2:0]  match_cnt;
    logic [31:0] fail_adr, fail_data;

    store_checker #(
        .DATA_W  (32),
        .ADR_W   (32),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_write  (mem_write),
        .data_adr   (data_adr),
        .write_data (write_data),
        .exp_we     (exp_we),
        .exp_adr    (exp_adr),
        .exp_data   (exp_data),
        .ign_en     (ign_en),
        .ign_adr    (ign_adr),
        .start      (start),
        .clear      (clear),
        .busy       (busy),
        .pass       (pass),
        .fail       (fail),
        .fail_code  (fail_code),
        .match_cnt  (match_cnt),
        .ovf        (ovf),
        .fail_adr   (fail_adr),
        .fail_data  (fail_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          ps;
        logic [1:0]  code;
        int          mc;
        bit          ovf;
        logic [31:0] fa;
        logic [31:0] fd;
    } outc_t;

    typedef struct {
        int cyc;
        int mc;
    } step_t;

    outc_t out_q[$];
    step_t step_q[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scenario description shared by directed and random tests
    int          n_push;
    logic [31:0] p_adr [8];
    logic [31:0] p_dat [8];
    bit          ig_en;
    logic [31:0] ig_adr;
    bit          s_we  [NSTEP];
    logic [31:0] s_adr [NSTEP];
    logic [31:0] s_dat [NSTEP];

    function automatic logic [31:0] rnd_adr();
        return 32'($urandom_range(0, 7)) << 2;
    endfunction

    task automatic no_stores();
        for (int k = 0; k < NSTEP; k++) begin
            s_we[k]  = 1'b0;
            s_adr[k] = '0;
            s_dat[k] = '0;
        end
    endtask

    task automatic gen_random();
        int gi;
        int r;
        bit quiet;
        n_push = $urandom_range(0, 6);
        for (int i = 0; i < n_push; i++) begin
            p_adr[i] = rnd_adr();
            p_dat[i] = 32'($urandom_range(0, 3));
        end
        ig_en  = $urandom_range(0, 1) == 1;
        ig_adr = rnd_adr();
        quiet  = $urandom_range(0, 4) == 0;
        gi     = 0;
        no_stores();
        for (int k = 0; k < NSTEP; k++) begin
            r = $urandom_range(0, 19);
            if (quiet) r = 19;
            if (r <= 7 && gi < n_push && gi < DEPTH) begin
                s_we[k] = 1'b1; s_adr[k] = p_adr[gi]; s_dat[k] = p_dat[gi]; gi++;
            end else if (r >= 8 && r <= 10) begin
                s_we[k] = 1'b1; s_adr[k] = ig_adr; s_dat[k] = $urandom;
            end else if (r == 11) begin
                s_we[k] = 1'b1; s_adr[k] = rnd_adr(); s_dat[k] = 32'($urandom_range(0, 3));
            end
        end
    endtask

    // Reference model: walks the store list against the held expectations.
    task automatic model(input int s_cyc);
        int    nh, mc;
        bit    done;
        outc_t o;
        step_t st;
        nh    = (n_push > DEPTH) ? DEPTH : n_push;
        o.ovf = n_push > DEPTH;
        o.fa  = '0;
        o.fd  = '0;
        o.ps  = 1'b0;
        if (nh == 0) begin
            o.cyc = s_cyc; o.code = 2'b11; o.mc = 0;
            out_q.push_back(o);
            return;
        end
        mc   = 0;
        done = 1'b0;
        for (int k = 0; k < NSTEP && !done; k++) begin
            if (s_we[k]) begin
                if (s_adr[k] == p_adr[mc] && s_dat[k] == p_dat[mc]) begin
                    mc++;
                    if (mc == nh) begin
                        done = 1'b1; o.ps = 1'b1; o.code = 2'b00;
                    end
                end else if (!(ig_en && s_adr[k] == ig_adr)) begin
                    done = 1'b1; o.code = 2'b01;
                    if (CAP) begin o.fa = s_adr[k]; o.fd = s_dat[k]; end
                end
            end
            if (!done && k == TIMEOUT - 1) begin
                done = 1'b1; o.code = 2'b10;
            end
            st.cyc = s_cyc + k + 1;
            st.mc  = mc;
            step_q.push_back(st);
            if (done) begin
                o.cyc = s_cyc + k + 1;
                o.mc  = mc;
                out_q.push_back(o);
            end
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
    endtask

    task automatic run_scenario();
        outc_t last;
        pulse_clear();
        for (int i = 0; i < n_push; i++) begin
            exp_we = 1'b1; exp_adr = p_adr[i]; exp_data = p_dat[i];
            mem_write = $urandom_range(0, 1) == 1; data_adr = $urandom; write_data = $urandom;
            @(negedge clk);
        end
        exp_we = 1'b0; mem_write = 1'b0;
        ign_en = ig_en; ign_adr = ig_adr;
        start = 1'b1;
        model(cyc + 1);
        last = out_q[out_q.size() - 1];
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < NSTEP; k++) begin
            mem_write = s_we[k]; data_adr = s_adr[k]; write_data = s_dat[k];
            exp_we = $urandom_range(0, 3) == 0; exp_adr = $urandom; exp_data = $urandom;
            start = $urandom_range(0, 3) == 0;
            @(negedge clk);
        end
        mem_write = 1'b0; exp_we = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("hold_pass", pass, last.ps);
        chk("hold_fail_code", fail_code, last.code);
        pulse_clear();
        chk("clear_busy_pass_fail", {busy, pass, fail}, 0);
        chk("clear_fail_code", fail_code, 0);
        chk("clear_match_cnt", match_cnt, 0);
        chk("clear_ovf", ovf, 0);
    endtask

    // Monitor: compares DUT against queued expectations as outputs appear.
    initial begin : monitor
        bit    prev;
        outc_t o;
        step_t s;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (step_q.size() > 0 && step_q[0].cyc == cyc) begin
                s = step_q.pop_front();
                chk("match_cnt_step", match_cnt, s.mc);
            end
            if ((pass || fail) && !prev) begin
                if (out_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_done: pass=%0b fail=%0b code=%0d (cycle %0d)", pass, fail, fail_code, cyc);
                end else begin
                    o = out_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(o.cyc));
                    chk("pass", pass, o.ps);
                    chk("fail", fail, !o.ps);
                    chk("fail_code", fail_code, o.code);
                    chk("match_cnt", match_cnt, 64'(o.mc));
                    chk("ovf", ovf, o.ovf);
                    chk("fail_adr", fail_adr, o.fa);
                    chk("fail_data", fail_data, o.fd);
                end
            end
            prev = pass || fail;
        end
    end

    initial begin : driver
        @(negedge clk);
        chk("reset_state", {busy, pass, fail}, 0);
        chk("reset_fail_code", fail_code, 0);
        chk("reset_match_cnt", match_cnt, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_capture", {fail_adr, fail_data}, 0);
        reset = 1'b1;

        // single matching store
        n_push = 1; p_adr[0] = 84; p_dat[0] = 28; ig_en = 0; ig_adr = 0;
        no_stores(); s_we[0] = 1; s_adr[0] = 84; s_dat[0] = 28;
        run_scenario();
        // scratch stores tolerated
        ig_en = 1; ig_adr = 80; no_stores();
        s_we[0] = 1; s_adr[0] = 80; s_dat[0] = 5;
        s_we[1] = 1; s_adr[1] = 80; s_dat[1] = 7;
        s_we[2] = 1; s_adr[2] = 84; s_dat[2] = 28;
        run_scenario();
        // same stores without ignore
        ig_en = 0;
        run_scenario();
        // data mismatch
        no_stores(); s_we[0] = 1; s_adr[0] = 84; s_dat[0] = 27;
        run_scenario();
        // timeout
        no_stores();
        run_scenario();
        // overflow, then in-order completion of the four held entries
        n_push = 5;
        for (int i = 0; i < 5; i++) begin p_adr[i] = 32'(100 + 4 * i); p_dat[i] = 32'(i + 1); end
        no_stores();
        for (int k = 0; k < 4; k++) begin s_we[2 * k] = 1; s_adr[2 * k] = p_adr[k]; s_dat[2 * k] = p_dat[k]; end
        run_scenario();
        // start on empty table
        n_push = 0; no_stores();
        run_scenario();

        for (int t = 0; t < 40; t++) begin
            gen_random();
            run_scenario();
        end

        // reset in the middle of a run after one of two matches
        pulse_clear();
        exp_we = 1; exp_adr = 16; exp_data = 1; @(negedge clk);
        exp_adr = 20; exp_data = 2; @(negedge clk);
        exp_we = 0; start = 1; @(negedge clk);
        start = 0; mem_write = 1; data_adr = 16; write_data = 1; @(negedge clk);
        mem_write = 0;
        chk("mid_run_busy", busy, 1);
        chk("mid_run_match_cnt", match_cnt, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_state", {busy, pass, fail}, 0);
        chk("async_reset_match_cnt", match_cnt, 0);
        @(negedge clk); reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_reset_quiet", {busy, pass, fail}, 0);
        end
        // table must be empty after reset
        begin
            outc_t o;
            o.cyc = cyc + 1; o.ps = 0; o.code = 2'b11; o.mc = 0; o.ovf = 0; o.fa = 0; o.fd = 0;
            out_q.push_back(o);
        end
        start = 1; @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);

        chk("pending_outcomes", out_q.size(), 0);
        chk("pending_steps", step_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
